key_scheduler: RTL and testbench

KEY_SCHEDULER -- requirements
Module: key_scheduler

---
 rtl/key_scheduler_if.sv | 15 +
 rtl/key_scheduler.sv | 122 ++++++++++++
 tb/tb_key_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/key_scheduler_if.sv
// rtl/key_scheduler_if.sv - round-key request/response bundle for key_scheduler
// Ports (slave view, as seen by key_scheduler):
//   En     in   1    advance key expansion one round per cycle
//   SelKey in   4    round-key index 0..10 (11..15 read zero)
//   Key    out  128  selected round key, row-major state layout
//   Ry     out  1    all 11 round keys valid
interface key_scheduler_if;
   logic         En;
   logic [3:0]   SelKey;
   logic [127:0] Key;
   logic         Ry;

   modport slave  (input En, SelKey, output Key, Ry);
   modport master (output En, SelKey, input Key, Ry);
endinterface

// File: rtl/key_scheduler.sv
// rtl/key_scheduler.sv - AES-128 key expansion with indexed round-key readout
// Ports:
//   Clk  in   sole clock, rising edge
//   Rst  in   synchronous active-low reset
//   bus  key_scheduler_if.slave (En, SelKey -> Key, Ry)
// Keys use row-major state layout: byte (r,c) at Key[127-8*(4r+c) -: 8],
// so each 32-bit slice is one state row and an expansion word is a column.
module key_scheduler #(
   parameter logic [127:0] INIT_KEY = 128'he6fad5a0c3ecf681b31e5d8e3aa15916
) (
   input  logic           Clk,
   input  logic           Rst,
   key_scheduler_if.slave bus
);

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   state_t         state_q, state_d;
   logic [3:0]     rnd_q, rnd_d;
   logic           ry_q, ry_d;
   logic [127:0]   keys_q [0:10];

   logic           store;
   logic [3:0]     rnd_nxt;
   logic [127:0]   prev_key;
   logic [31:0]    w3;
   logic [31:0]    temp;
   logic [127:0]   next_key;

   // Entry x sits (255-x) bytes up from bit 0; ~x == 255-x for 8 bits.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // One state row after the w0..w3 XOR chain: each column XORs in the
   // freshly computed column to its left, seeded with that row's temp byte.
   function automatic logic [31:0] row_next(input logic [31:0] row, input logic [7:0] t);
      logic [7:0] b0, b1, b2, b3;
      b0 = row[31:24] ^ t;
      b1 = row[23:16] ^ b0;
      b2 = row[15:8]  ^ b1;
      b3 = row[7:0]   ^ b2;
      return {b0, b1, b2, b3};
   endfunction

   // Round datapath: derive key rnd+1 from stored key rnd.
   always_comb begin
      rnd_nxt  = rnd_q + 4'd1;
      prev_key = keys_q[rnd_q];
      w3       = {prev_key[103:96], prev_key[71:64], prev_key[39:32], prev_key[7:0]};
      temp     = {sbox(w3[23:16]) ^ rcon(rnd_nxt), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      next_key = {row_next(prev_key[127:96], temp[31:24]),
                  row_next(prev_key[95:64],  temp[23:16]),
                  row_next(prev_key[63:32],  temp[15:8]),
                  row_next(prev_key[31:0],   temp[7:0])};
   end

   // State register
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q   <= IDLE;
         rnd_q     <= 4'd0;
         ry_q      <= 1'b0;
         keys_q[0] <= INIT_KEY;
         for (int i = 1; i <= 10; i++) keys_q[i] <= '0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         ry_q    <= ry_d;
         if (store) keys_q[rnd_d] <= next_key;
      end
   end

   // Next-state logic; the IDLE->EXPAND cycle already stores key 1.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.En) state_d = EXPAND;
         EXPAND:  if (bus.En && rnd_q == 4'd9) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs and datapath control
   always_comb begin
      store   = bus.En && (state_q == IDLE || state_q == EXPAND);
      rnd_d   = store ? rnd_nxt : rnd_q;
      ry_d    = (state_d == DONE);
      bus.Ry  = ry_q;
      bus.Key = (bus.SelKey <= 4'd10) ? keys_q[bus.SelKey] : '0;
   end

endmodule

// File: tb/tb_key_scheduler.sv
// tb/tb_key_scheduler.sv - directed-vector bench for key_scheduler
// Two instances share Clk/Rst/En: default INIT_KEY and the FIPS-197 key.
module tb_key_scheduler;

   logic Clk = 1'b0;
   logic Rst;
   always #50 Clk = ~Clk;

   key_scheduler_if bus_a();
   key_scheduler_if bus_b();

   key_scheduler u_dut_a (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus_a)
   );

   key_scheduler #(
      .INIT_KEY (128'h2b28ab097eaef7cf15d2154f16a6883c)
   ) u_dut_b (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus_b)
   );

   logic [127:0] exp_keys [0:10] = '{
      128'he6fad5a0c3ecf681b31e5d8e3aa15916,
      128'heb11c464da36c041f4eab739da7b2234,
      128'h6a7bbfdbc8fe3e7fec06b18899e2c0f4,
      128'hbcc778a30cf2ccb35355e46c20c202f6,
      128'hd91e66c55cae62d11144a0cc2ae8ea1c,
      128'hf7e98f4a17b9db0a8dc969a58c648e92,
      128'hb059d69c11a87379c20b62c75a3eb022,
      128'h461fc955d77f0c75515a38ff84ba0a28,
      128'h5b448dd8c1beb2c7653f07f878c2c8e0,
      128'h86c24f97803e8c4b84bbbc4419db13f3,
      128'h03c18e199ba5296289328eca914a59aa
   };

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_en(input logic v);
      bus_a.En = v;
      bus_b.En = v;
   endtask

   task automatic check_key_a(input string tag, input int sel, input logic [127:0] exp);
      bus_a.SelKey = 4'(sel);
      #1;
      check($sformatf("%s_key%0d", tag, sel), bus_a.Key, exp);
   endtask

   task automatic check_all_keys(input string tag);
      for (int i = 0; i < 16; i++)
         check_key_a(tag, i, (i <= 10) ? exp_keys[i] : 128'h0);
   endtask

   task automatic check_cleared(input string tag);
      for (int i = 0; i <= 10; i++)
         check_key_a(tag, i, (i == 0) ? exp_keys[0] : 128'h0);
   endtask

   initial begin
      int en_cnt;

      Rst = 1'b0;
      set_en(1'b1);
      bus_a.SelKey = 4'd0;
      bus_b.SelKey = 4'd0;

      // Reset overrides En
      tick();
      tick();
      check("rst_ry_a", bus_a.Ry, 1'b0);
      check("rst_ry_b", bus_b.Ry, 1'b0);
      check_cleared("rst");
      bus_b.SelKey = 4'd0;
      #1;
      check("rst_b_key0", bus_b.Key, 128'h2b28ab097eaef7cf15d2154f16a6883c);

      // Continuous expansion, 12 enabled edges; last two exercise DONE ignoring En
      Rst = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         tick();
         check($sformatf("run_ry_e%0d", e), bus_a.Ry, e >= 10);
         check($sformatf("run_ry_b_e%0d", e), bus_b.Ry, e >= 10);
      end
      check_all_keys("run");
      bus_b.SelKey = 4'd1;
      #1;
      check("fips_key1", bus_b.Key, 128'ha088232afa54a36cfe2c397617b13905);
      bus_b.SelKey = 4'd10;
      #1;
      check("fips_key10", bus_b.Key, 128'hd0c9e1b614ee3f63f9250c0ca889c8a6);

      // Toggled enable: Ry on the 10th enabled edge, pauses hold state
      Rst = 1'b0;
      set_en(1'b0);
      tick();
      Rst = 1'b1;
      en_cnt = 0;
      for (int cyc = 0; cyc < 22; cyc++) begin
         set_en(cyc % 2 == 0);
         tick();
         if (cyc % 2 == 0) en_cnt++;
         check($sformatf("tog_ry_c%0d", cyc), bus_a.Ry, en_cnt >= 10);
         if (en_cnt == 3 && cyc % 2 == 0) begin
            check_key_a("tog_partial", 3, exp_keys[3]);
            check_key_a("tog_partial", 4, 128'h0);
         end
      end
      check_all_keys("tog");

      // Reset at round 5 aborts; expansion restarts from round 1
      Rst = 1'b0;
      set_en(1'b0);
      tick();
      Rst = 1'b1;
      set_en(1'b1);
      repeat (5) tick();
      check_key_a("abort_pre", 5, exp_keys[5]);
      check_key_a("abort_pre", 6, 128'h0);
      Rst = 1'b0;
      tick();
      check("abort_ry", bus_a.Ry, 1'b0);
      check_cleared("abort");
      Rst = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         tick();
         check($sformatf("re_ry_e%0d", e), bus_a.Ry, e == 10);
         if (e == 1) begin
            check_key_a("re_first", 1, exp_keys[1]);
            check_key_a("re_first", 2, 128'h0);
         end
      end
      check_all_keys("re");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
